// File: rtl/img_pkg.sv
// Shared image geometry, pixel/FIFO entry layout and the reader state
// encoding for the frame stream reader and its FIFO.
//
// Contents:
//   IMG_W, IMG_H, NUM_PIX : frame geometry (320 x 240 = 76800 pixels)
//   PIX_W, ADDR_W         : RAM word width and linear address width
//   COL_W, ROW_W          : widths of the column/row counters
//   COL_LAST, ROW_LAST    : typed last-column / last-row constants
//   state_e               : reader FSM states
//   pix_entry_t           : one FIFO entry, pixel word plus position flags
package img_pkg;

  localparam int IMG_W   = 320;
  localparam int IMG_H   = 240;
  localparam int NUM_PIX = IMG_W * IMG_H;
  localparam int PIX_W   = 32;
  localparam int ADDR_W  = 17;
  localparam int COL_W   = 9;
  localparam int ROW_W   = 8;
  localparam int FLAG_W  = 4;
  localparam int ENTRY_W = PIX_W + FLAG_W;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sof;
    logic             eof;
    logic             sol;
    logic             eol;
  } pix_entry_t;

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry FIFO holding pixel words with their position flags.
//
// Ports:
//   clk      : clock, all state on the rising edge
//   rst_n    : asynchronous active-low reset, empties the FIFO
//   push_i   : write wdata_i (accepted when not full, or full with a pop)
//   wdata_i  : entry to write
//   pop_i    : remove the head entry (ignored when empty)
//   rdata_o  : head entry
//   full_o   : two entries held
//   empty_o  : no entries held
//   count_o  : number of entries held (0..2)
module pix_fifo2
  import img_pkg::*;
#(
  parameter int W = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i & (count_q != 2'd0);
  // When full, wr_ptr equals rd_ptr: a push with a pop overwrites the slot
  // being consumed at this same edge, so ordering is preserved.
  assign do_push = push_i & ((count_q != 2'd2) | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/frame_stream_reader.sv
// Reads one 320x240 frame out of a RAM read port in raster order and
// streams it as valid/ready pixel beats with frame/row position flags.
//
// Ports:
//   clk        : clock
//   reset_n    : asynchronous active-low reset
//   start      : level; a frame starts on its 0->1 transition while idle
//   en_r_n     : active-low RAM read enable
//   addr_r     : linear read address 0..76799
//   data_r     : RAM read data, valid combinationally with addr_r
//   pix_valid  : beat valid (FIFO not empty)
//   pix_ready  : downstream accepts the beat
//   pix_data   : pixel word
//   pix_sof/eof/sol/eol : first/last pixel of frame / of row
//   busy       : streaming or draining
//   frame_done : one-cycle pulse after the final transfer
module frame_stream_reader
  import img_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              en_r_n,
  output logic [ADDR_W-1:0] addr_r,
  input  logic [PIX_W-1:0]  data_r,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_sof,
  output logic              pix_eof,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              busy,
  output logic              frame_done
);

  state_e            state_q, state_d;
  logic              start_d_q;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  pix_entry_t        push_entry;
  pix_entry_t        head_entry;

  logic start_edge, pop, rd_en;
  logic at_sof, at_eof, at_sol, at_eol;

  assign start_edge = start & ~start_d_q;
  assign pop        = ~fifo_empty & pix_ready;
  // A read may be issued whenever its entry fits, counting a pop this cycle.
  assign rd_en      = (state_q == STREAM) & (~fifo_full | pop);

  assign at_sol = (col_q == '0);
  assign at_eol = (col_q == COL_LAST);
  assign at_sof = at_sol & (row_q == '0);
  assign at_eof = at_eol & (row_q == ROW_LAST);

  assign push_entry = '{data: data_r, sof: at_sof, eof: at_eof,
                        sol: at_sol, eol: at_eol};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      start_d_q <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      start_d_q <= start;
      col_q     <= col_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = STREAM;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end
      STREAM: begin
        if (rd_en) begin
          if (at_eof) begin
            // Counters return to zero so addr_r rests at 0 between frames.
            state_d = DRAIN;
            col_d   = '0;
            row_d   = '0;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (at_eol) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (pop && (fifo_count == 2'd1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  pix_fifo2 #(.W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (rd_en),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign en_r_n     = ~rd_en;
  assign addr_r     = addr_q;
  assign pix_valid  = ~fifo_empty;
  assign pix_data   = head_entry.data;
  assign pix_sof    = head_entry.sof;
  assign pix_eof    = head_entry.eof;
  assign pix_sol    = head_entry.sol;
  assign pix_eol    = head_entry.eol;
  assign busy       = (state_q == STREAM) | (state_q == DRAIN);
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_frame_stream_reader.sv
// Directed bench for frame_stream_reader: reset values, start-of-frame
// stall, one full frame with a toggling-ready prefix, start retrigger
// rules, mid-frame reset and restart from address 0.
module tb_frame_stream_reader;
  import img_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              start = 1'b0;
  logic              pix_ready = 1'b0;
  logic              en_r_n;
  logic [ADDR_W-1:0] addr_r;
  logic [PIX_W-1:0]  data_r;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_sof, pix_eof, pix_sol, pix_eol;
  logic              busy, frame_done;

  bit mode = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int beat_idx = 0;
  int sol_cnt = 0;
  int eol_cnt = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  // RAM model: word content depends on address; garbage when not enabled.
  assign data_r = en_r_n ? 32'hDEAD_BEEF
                : (mode ? {~addr_r[7:0], 7'b0, addr_r} : {15'b0, addr_r});

  frame_stream_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .en_r_n     (en_r_n),
    .addr_r     (addr_r),
    .data_r     (data_r),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .pix_eof    (pix_eof),
    .pix_sol    (pix_sol),
    .pix_eol    (pix_eol),
    .busy       (busy),
    .frame_done (frame_done)
  );

  function automatic logic [31:0] exp_data(input int i);
    logic [16:0] a;
    a = 17'(i);
    return mode ? {~a[7:0], 7'b0, a} : {15'b0, a};
  endfunction

  function automatic logic [3:0] exp_flags(input int i);
    int c;
    c = i % IMG_W;
    return {i == 0, i == NUM_PIX - 1, c == 0, c == IMG_W - 1};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (beat %0d, t=%0t)",
               tag, got, exp, beat_idx, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".en_r_n"},     64'(en_r_n),     64'd1);
    check({tag, ".addr_r"},     64'(addr_r),     64'd0);
    check({tag, ".pix_valid"},  64'(pix_valid),  64'd0);
    check({tag, ".flags"},      64'({pix_sof, pix_eof, pix_sol, pix_eol}), 64'd0);
    check({tag, ".busy"},       64'(busy),       64'd0);
    check({tag, ".frame_done"}, 64'(frame_done), 64'd0);
  endtask

  // Consume beats until 'target' have transferred; ready alternates while
  // beat_idx < toggle_until, otherwise held high.
  task automatic run_beats(input string name, input int target, input int toggle_until);
    int cyc;
    int budget;
    cyc = 0;
    budget = target * 3 + 64;
    while (beat_idx < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
      pix_ready = (beat_idx < toggle_until) ? cyc[0] : 1'b1;
      #1;
      if (frame_done) done_pulses++;
      if (pix_valid) begin
        check("pix_data", 64'(pix_data), 64'(exp_data(beat_idx)));
        check("flags", 64'({pix_sof, pix_eof, pix_sol, pix_eol}), 64'(exp_flags(beat_idx)));
        if (pix_ready) begin
          if (pix_sol) sol_cnt++;
          if (pix_eol) eol_cnt++;
          beat_idx++;
        end
      end
    end
    check("beat_budget", 64'(beat_idx), 64'(target));
    $display("%s: %0d beats in %0d cycles", name, beat_idx, cyc);
  endtask

  initial begin
    int reads;
    int stray;

    // Reset state
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_idle_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_idle_outputs("idle");

    // Frame 1: ready low for the first 10 cycles
    mode = 1'b0;
    beat_idx = 0;
    reads = 0;
    start = 1'b1;
    pix_ready = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      #1;
      if (!en_r_n) reads++;
      if (c == 1) begin
        check("s1.busy",      64'(busy),      64'd1);
        check("s1.en_r_n",    64'(en_r_n),    64'd0);
        check("s1.addr_r",    64'(addr_r),    64'd0);
        check("s1.pix_valid", 64'(pix_valid), 64'd0);
      end else if (c == 2) begin
        check("s2.pix_valid", 64'(pix_valid), 64'd1);
        check("s2.pix_data",  64'(pix_data),  64'(exp_data(0)));
        check("s2.flags",     64'({pix_sof, pix_eof, pix_sol, pix_eol}), 64'(exp_flags(0)));
        check("s2.addr_r",    64'(addr_r),    64'd1);
      end else begin
        check("stall.en_r_n",   64'(en_r_n),   64'd1);
        check("stall.addr_r",   64'(addr_r),   64'd2);
        check("stall.pix_data", 64'(pix_data), 64'(exp_data(0)));
      end
    end
    check("stall.reads", 64'(reads), 64'd2);
    $display("stall: %0d reads issued during 10 stalled cycles", reads);

    sol_cnt = 0;
    eol_cnt = 0;
    done_pulses = 0;
    run_beats("frame1", NUM_PIX, 600);
    check("frame1.sol_cnt", 64'(sol_cnt), 64'(IMG_H));
    check("frame1.eol_cnt", 64'(eol_cnt), 64'(IMG_H));
    check("frame1.early_done", 64'(done_pulses), 64'd0);
    @(negedge clk);
    #1;
    check("done.frame_done", 64'(frame_done), 64'd1);
    check("done.busy",       64'(busy),       64'd0);
    check("done.pix_valid",  64'(pix_valid),  64'd0);
    @(negedge clk);
    #1;
    check("after.frame_done", 64'(frame_done), 64'd0);

    // start still high: no retrigger
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (busy || frame_done || !en_r_n) stray++;
    end
    check("hold_start.retrigger", 64'(stray), 64'd0);
    $display("hold_start: %0d active cycles with start held high", stray);

    // Frame 2 after a fresh 0->1, abandoned by reset at beat 1000
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    mode = 1'b1;
    beat_idx = 0;
    done_pulses = 0;
    run_beats("frame2", 1000, 0);
    reset_n = 1'b0;
    start = 1'b0;
    #1 check_idle_outputs("midreset");
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (frame_done) stray++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (frame_done || busy) stray++;
    end
    check("midreset.no_done", 64'(stray + done_pulses), 64'd0);

    // Frame 3 restarts from address 0
    mode = 1'b0;
    beat_idx = 0;
    start = 1'b1;
    run_beats("frame3", 500, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_stream_reader.md
FRAME_STREAM_READER -- requirements
Module: frame_stream_reader

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 Port start, input, 1: level from the image-transform block's done; a frame starts on its 0->1 transition.
REQ-004 Port en_r_n, output, 1: active-low read enable to the 2r/2w RAM read port.
REQ-005 Port addr_r, output, 17: linear pixel read address, 0..76799.
REQ-006 Port data_r, input, 32: RAM read data, valid combinationally in the same cycle as addr_r with en_r_n=0.
REQ-007 Port pix_valid, output, 1: pixel beat valid.
REQ-008 Port pix_ready, input, 1: downstream accepts the beat; transfer = pix_valid & pix_ready at a clk edge.
REQ-009 Port pix_data, output, 32: pixel word, bits [23:0] RGB, [31:24] passed unchanged.
REQ-010 Ports pix_sof, pix_eof, pix_sol, pix_eol, output, 1 each: first/last pixel of frame, first/last pixel of row; qualified by pix_valid.
REQ-011 Port busy, output, 1: high while state is STREAM or DRAIN.
REQ-012 Port frame_done, output, 1: one-cycle pulse when a frame completes.

Function
REQ-013 FSM states: IDLE, STREAM, DRAIN, DONE.
REQ-014 IDLE->STREAM on the edge where start=1 and the registered start_d=0; the read counters are zeroed.
REQ-015 STREAM: en_r_n=0 when the FIFO has space (count<2, or count==2 with a transfer this cycle); otherwise en_r_n=1 and addr_r holds.
REQ-016 Each enabled read pushes {data_r, sof, eof, sol, eol} into a 2-entry FIFO and advances col (0..319) then row (0..239); addr_r = row*320+col, built by increment only, no multiplier.
REQ-017 Flags: sof at addr 0, eof at addr 76799, sol at col 0, eol at col 319.
REQ-018 STREAM->DRAIN on the edge that reads addr 76799; no further reads are issued in DRAIN.
REQ-019 DRAIN->DONE on the edge of the transfer that empties the FIFO; frame_done=1 for exactly the following cycle, in DONE; DONE->IDLE on the next edge.
REQ-020 pix_valid = FIFO not empty; the head entry drives pix_data and the flags.
REQ-021 While pix_valid=1 and pix_ready=0, pix_data and the flags shall stay stable; no beat is lost or duplicated.
REQ-022 Latency: the first pix_valid occurs 2 cycles after the start edge is sampled. Throughput is 1 beat/cycle with pix_ready held high; a frame is exactly 76800 transfers.
REQ-023 A start edge outside IDLE is ignored. start held high after a frame shall not retrigger; a new frame needs start to go 0 then 1.
REQ-024 A simultaneous FIFO push and pop at count==2 keeps count at 2 and preserves order.

Reset
REQ-025 reset_n=0 forces: state IDLE, FIFO empty, row=col=0, start_d=0, en_r_n=1, addr_r=0, pix_valid=0, all flags 0, busy=0, frame_done=0.
REQ-026 Reset mid-frame abandons the frame with no frame_done; the next start edge restarts at addr 0.

Structure
REQ-027 Shared package img_pkg holds IMG_W=320, IMG_H=240, NUM_PIX=76800, PIX_W=32, ADDR_W=17 and the state enum.
REQ-028 Sub-module pix_fifo2 is a 2-entry FIFO with push/pop/full/empty, 36 bits wide (32 data + 4 flags).
REQ-029 Target size is 120-400 lines of RTL; no memory is instantiated inside the block.

Verification
REQ-030 RAM preloaded with mem[i]=i, pix_ready=1, start 0->1: 76800 beats with data 0..76799 in order; sof on beat 0; eof on beat 76799; frame_done pulses once, 1 cycle after the last transfer.
REQ-031 pix_ready toggling 1,0,1,0: data stable while stalled, sequence complete and gap-free, no duplicates.
REQ-032 pix_ready=0 for 10 cycles at frame start: exactly 2 reads issued, then en_r_n=1 and addr_r=2 held until pix_ready returns.
REQ-033 Row flags: sol on beats where index%320==0, eol on beats where index%320==319; 240 of each per frame.
REQ-034 start held high after frame_done: no second frame; start 0 then 1: a second full frame from addr 0.
REQ-035 reset_n pulsed low at beat 1000: all outputs take their reset values, no frame_done; the next start yields a full 76800-beat frame.
